// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter for two sources: ALU and MEM (load/multicycle).
// ALU has priority on a conflict. A MEM request that keeps losing is forced to
// win once its loss streak reaches STARVE_LIMIT. The winner is written to the
// register-file port one cycle later.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_rd_data,
  output logic [15:0] conflict_cnt
);

  typedef enum logic {ALU_PRI, MEM_FORCE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt, starve_inc;
  logic       alu_hs, mem_hs;

  // Grant: a lone source wins outright; on a conflict the state picks the winner.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      alu_ready = alu_valid && (!mem_valid || state == ALU_PRI);
      mem_ready = mem_valid && (!alu_valid || state == MEM_FORCE);
    end
  end

  assign alu_hs     = alu_valid && alu_ready;
  assign mem_hs     = mem_valid && mem_ready;
  assign starve_inc = starve_cnt + 4'd1;

  // Next state: count MEM losses in ALU_PRI; leave MEM_FORCE once a real
  // (rd != 0) MEM write goes through or MEM withdraws its request.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ALU_PRI: begin
        if (!mem_valid || mem_hs) begin
          starve_nxt = 4'd0;
        end else begin
          starve_nxt = starve_inc;
          if (starve_inc == LIMIT) state_nxt = MEM_FORCE;
        end
      end
      MEM_FORCE: begin
        if (!mem_valid || (mem_hs && mem_rd != 5'd0)) begin
          state_nxt  = ALU_PRI;
          starve_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt  = ALU_PRI;
        starve_nxt = 4'd0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ALU_PRI;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Writeback register: rd=0 writes are accepted but suppressed (addr reads 0,
  // data keeps its last value).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= 5'd0;
      rf_rd_data <= 32'd0;
    end else begin
      rf_we <= 1'b0;
      if (alu_hs) begin
        rf_we      <= (alu_rd != 5'd0);
        rf_rd_addr <= alu_rd;
        if (alu_rd != 5'd0) rf_rd_data <= alu_data;
      end else if (mem_hs) begin
        rf_we      <= (mem_rd != 5'd0);
        rf_rd_addr <= mem_rd;
        if (mem_rd != 5'd0) rf_rd_data <= mem_data;
      end
    end
  end

  // Saturating count of cycles with both sources requesting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (alu_valid && mem_valid && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand-written
// corner sequences (forced-grant withdrawal, async reset, counter saturation),
// then random traffic against a behavioural reference model.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: streak = consecutive cycles MEM was pending and lost
  // (a suppressed rd=0 win under force does not end it).
  int          m_streak;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cc;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [15:0] e_cc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
    m_cc     = 0;
  endtask

  // Entered and left at posedge+1. Drives one request set, checks the readys
  // mid-cycle and the registered outputs just after the edge.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       output logic ar_s, output logic mr_s);
    logic forced, ga, gm;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    @(negedge clk);
    forced = (m_streak >= LIMIT);
    ga = av && (!mv || !forced);
    gm = mv && (!av || forced);
    ar_s = alu_ready;
    mr_s = mem_ready;
    chk("alu_ready", alu_ready, ga);
    chk("mem_ready", mem_ready, gm);
    m_we = 1'b0;
    if (ga) begin
      m_we = (ard != 0); m_addr = ard;
      if (ard != 0) m_data = ad;
    end else if (gm) begin
      m_we = (mrd != 0); m_addr = mrd;
      if (mrd != 0) m_data = md;
    end
    if (av && mv && m_cc < 65535) m_cc++;
    if (!mv) m_streak = 0;
    else if (gm) begin
      if (!forced || mrd != 0) m_streak = 0;
    end else m_streak++;
    @(posedge clk); #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_rd_addr", rf_rd_addr, m_addr);
    chk("rf_rd_data", rf_rd_data, m_data);
    chk("conflict_cnt", conflict_cnt, m_cc);
  endtask

  // Assert reset away from the clock edge, release at posedge+1.
  task automatic do_reset();
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic ar, mr;
    model_reset();
    //            av ard   ad            mv mrd   md            ar mr we addr  data          cc
    vecs[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 1, 5'd5, 32'hDEADBEEF, 16'd0};
    vecs[1] = '{1, 5'd1, 32'h11,       1, 5'd2, 32'h22,       1, 0, 1, 5'd1, 32'h11,       16'd1};
    vecs[2] = '{1, 5'd3, 32'h33,       1, 5'd2, 32'h22,       1, 0, 1, 5'd3, 32'h33,       16'd2};
    vecs[3] = '{1, 5'd4, 32'h44,       1, 5'd2, 32'h22,       1, 0, 1, 5'd4, 32'h44,       16'd3};
    vecs[4] = '{1, 5'd4, 32'h44,       1, 5'd6, 32'h66,       0, 1, 1, 5'd6, 32'h66,       16'd4};
    vecs[5] = '{1, 5'd7, 32'h77,       1, 5'd6, 32'h66,       1, 0, 1, 5'd7, 32'h77,       16'd5};
    vecs[6] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 5'd7, 32'h77,       16'd5};
    vecs[7] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h99,       0, 1, 0, 5'd0, 32'h77,       16'd5};
    vecs[8] = '{0, 5'd0, 32'h0,        1, 5'd9, 32'hAA,       0, 1, 1, 5'd9, 32'hAA,       16'd5};

    // Reset state, including readys held low with requests present.
    rst = 1'b1;
    alu_valid = 1'b1; mem_valid = 1'b1;
    alu_rd = 5'd1; mem_rd = 5'd2; alu_data = '0; mem_data = '0;
    #2;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_addr", rf_rd_addr, 5'd0);
    chk("rst_data", rf_rd_data, 32'd0);
    chk("rst_cc", conflict_cnt, 16'd0);
    do_reset();

    // Directed table; first entry hits the first edge after reset release.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md, ar, mr);
      chk($sformatf("vec%0d_ar", i), ar, vecs[i].e_ar);
      chk($sformatf("vec%0d_mr", i), mr, vecs[i].e_mr);
      chk($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
      chk($sformatf("vec%0d_addr", i), rf_rd_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), rf_rd_data, vecs[i].e_data);
      chk($sformatf("vec%0d_cc", i), conflict_cnt, vecs[i].e_cc);
    end

    // Forced MEM withdraws before its grant: ALU wins, counter clears.
    do_reset();
    repeat (3) cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, ar, mr);
    chk("force_starve_cnt", dut.starve_cnt, 4'd3);
    cycle(1, 5'd12, 32'hC0, 0, 5'd0, 32'h0, ar, mr);
    chk("drop_alu_ready", ar, 1'b1);
    chk("drop_starve_cnt", dut.starve_cnt, 4'd0);
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("drop_then_alu_pri", alu_ready, 1'b1);
    #1;
    cycle(1, 5'd13, 32'hD0, 1, 5'd14, 32'hE0, ar, mr);
    chk("drop_then_alu_wr", rf_rd_addr, 5'd13);

    // Async reset just after a grant: write vanishes at once, none afterwards.
    cycle(1, 5'd15, 32'hF00D, 1, 5'd16, 32'h1, ar, mr);
    chk("pre_rst_we", rf_we, 1'b1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_we", rf_we, 1'b0);
    chk("async_rst_cc", conflict_cnt, 16'd0);
    chk("async_rst_addr", rf_rd_addr, 5'd0);
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_no_write", rf_we, 1'b0);
    end

    // Saturate the conflict counter, then one more conflict.
    do_reset();
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd1; mem_rd = 5'd2;
    repeat (65535) @(posedge clk);
    #1 chk("cc_at_max", conflict_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("cc_saturated", conflict_cnt, 16'hFFFF);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic       av, mv;
      logic [4:0] ard, mrd;
      av  = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 3) != 0);
      ard = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle(av, ard, $urandom, mv, mrd, $urandom, ar, mr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
